// File: rtl/cpu_dmem_arbiter.sv
// cpu_dmem_arbiter: shares one 16-bit big-endian Wishbone data port between two requesters.
// Optional build macro MOXIE_DMEM_WATCHDOG_EN aborts a beat after WDOG_CYCLES wait states.
module cpu_dmem_arbiter #(
   parameter int unsigned WDOG_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        req0_i,
   input  logic        we0_i,
   input  logic [1:0]  size0_i,
   input  logic [31:0] addr0_i,
   input  logic [31:0] wdata0_i,
   output logic        ack0_o,
   output logic        err0_o,
   output logic [31:0] rdata0_o,
   input  logic        req1_i,
   input  logic        we1_i,
   input  logic [1:0]  size1_i,
   input  logic [31:0] addr1_i,
   input  logic [31:0] wdata1_i,
   output logic        ack1_o,
   output logic        err1_o,
   output logic [31:0] rdata1_o,
   output logic [31:0] wb_adr_o,
   output logic [15:0] wb_dat_o,
   input  logic [15:0] wb_dat_i,
   output logic [1:0]  wb_sel_o,
   output logic        wb_we_o,
   output logic        wb_stb_o,
   output logic        wb_cyc_o,
   input  logic        wb_ack_i
);
   localparam logic [1:0] SZ_BYTE  = 2'b00;
   localparam logic [1:0] SZ_SHORT = 2'b01;
   localparam logic [1:0] SZ_LONG  = 2'b10;

   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_e;

   state_e      state_q, state_d;
   logic        port_q, port_d, we_q, we_d, err_q, err_d;
   logic [1:0]  size_q, size_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;

   // Port 1 carries the older instruction, so it wins whenever it asks.
   logic        g_we, g_illegal;
   logic [1:0]  g_size;
   logic [31:0] g_addr, g_wdata;
   assign g_we      = req1_i ? we1_i    : we0_i;
   assign g_size    = req1_i ? size1_i  : size0_i;
   assign g_addr    = req1_i ? addr1_i  : addr0_i;
   assign g_wdata   = req1_i ? wdata1_i : wdata0_i;
   assign g_illegal = (g_size == 2'b11) || ((g_size != SZ_BYTE) && g_addr[0]);

`ifdef MOXIE_DMEM_WATCHDOG_EN
   localparam int unsigned WdW = $clog2(WDOG_CYCLES + 1);
   logic [WdW-1:0] wdog_q, wdog_d;
   logic           wdog_expire;
   assign wdog_expire = (wdog_q == WdW'(WDOG_CYCLES - 1));
`endif

   always_comb begin
      state_d  = state_q;
      port_d   = port_q;
      we_d     = we_q;
      err_d    = err_q;
      size_d   = size_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      wb_adr_o = '0;
      wb_dat_o = '0;
      wb_sel_o = '0;
      wb_we_o  = 1'b0;
      wb_stb_o = 1'b0;
      wb_cyc_o = 1'b0;
`ifdef MOXIE_DMEM_WATCHDOG_EN
      wdog_d   = wdog_q;
`endif
      case (state_q)
         IDLE: begin
            if (req0_i || req1_i) begin
               port_d  = req1_i;
               we_d    = g_we;
               size_d  = g_size;
               addr_d  = g_addr;
               wdata_d = g_wdata;
               rdata_d = '0;
               err_d   = g_illegal;
               state_d = g_illegal ? RESP : BEAT0;
`ifdef MOXIE_DMEM_WATCHDOG_EN
               wdog_d  = '0;
`endif
            end
         end
         BEAT0: begin
            wb_cyc_o = 1'b1;
            wb_stb_o = 1'b1;
            wb_we_o  = we_q;
            wb_adr_o = {addr_q[31:1], 1'b0};
            case (size_q)
               SZ_BYTE: begin
                  wb_sel_o = addr_q[0] ? 2'b01 : 2'b10;
                  wb_dat_o = {2{wdata_q[7:0]}};
               end
               SZ_SHORT: begin
                  wb_sel_o = 2'b11;
                  wb_dat_o = wdata_q[15:0];
               end
               default: begin
                  wb_sel_o = 2'b11;
                  wb_dat_o = wdata_q[31:16];
               end
            endcase
            if (wb_ack_i) begin
               if (!we_q) begin
                  case (size_q)
                     SZ_BYTE:  rdata_d = {24'b0, addr_q[0] ? wb_dat_i[7:0] : wb_dat_i[15:8]};
                     SZ_SHORT: rdata_d = {16'b0, wb_dat_i};
                     default:  rdata_d = {wb_dat_i, 16'b0};
                  endcase
               end
               state_d = (size_q == SZ_LONG) ? BEAT1 : RESP;
`ifdef MOXIE_DMEM_WATCHDOG_EN
               wdog_d  = '0;
            end else if (wdog_expire) begin
               state_d = RESP;
               err_d   = 1'b1;
               rdata_d = '0;
            end else begin
               wdog_d  = wdog_q + 1'b1;
`endif
            end
         end
         BEAT1: begin
            wb_cyc_o = 1'b1;
            wb_stb_o = 1'b1;
            wb_we_o  = we_q;
            wb_adr_o = {addr_q[31:1] + 31'd1, 1'b0};
            wb_sel_o = 2'b11;
            wb_dat_o = wdata_q[15:0];
            if (wb_ack_i) begin
               if (!we_q) rdata_d = {rdata_q[31:16], wb_dat_i};
               state_d = RESP;
`ifdef MOXIE_DMEM_WATCHDOG_EN
            end else if (wdog_expire) begin
               state_d = RESP;
               err_d   = 1'b1;
               rdata_d = '0;
            end else begin
               wdog_d  = wdog_q + 1'b1;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         port_q  <= 1'b0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         size_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
`ifdef MOXIE_DMEM_WATCHDOG_EN
         wdog_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         port_q  <= port_d;
         we_q    <= we_d;
         err_q   <= err_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
`ifdef MOXIE_DMEM_WATCHDOG_EN
         wdog_q  <= wdog_d;
`endif
      end
   end

   // Response lines are gated by RESP so rdata/err read as zero outside the ack pulse.
   assign ack0_o   = (state_q == RESP) && !port_q;
   assign ack1_o   = (state_q == RESP) &&  port_q;
   assign err0_o   = ack0_o && err_q;
   assign err1_o   = ack1_o && err_q;
   assign rdata0_o = ack0_o ? rdata_q : '0;
   assign rdata1_o = ack1_o ? rdata_q : '0;
endmodule
